// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the MIPS instruction-fetch stage: FSM state encodings,
// the NOP and HALT instruction words, and the PC increment helper.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_BOOT       = 2'd0,
    ST_RUN        = 2'd1,
    ST_REDIR_PEND = 2'd2,
    ST_HALT       = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

  // Next sequential instruction address; wraps modulo 2^32.
  function automatic logic [31:0] add4(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: valid/instr/pc4 with async clear, load enable and
// squash. Squash wins over load and turns the slot into a NOP while keeping pc4.
module fetch_stage_ifid_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        squash,
  input  logic        valid_in,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc4
);

  // Capture, squash or hold the decode-side instruction slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc4   <= 32'h0;
    end else if (squash) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (load) begin
      valid <= valid_in;
      instr <= instr_in;
      pc4   <= pc4_in;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register. Owns the PC, addresses the
// instruction ROM, honours stall/redirect from decode and stops on HALT.
// Build option: FETCH_DELAY_SLOT_EN keeps the word fetched in a redirect cycle
// (branch delay slot) valid instead of squashing it.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = HALT_WORD,
  parameter int          IMEM_AW    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic               ifid_valid,
  output logic [31:0]        ifid_instr,
  output logic [31:0]        ifid_pc4,
  output logic [31:0]        pc_out,
  output logic               halted
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next;
  logic [31:0]  pend_pc, pend_next;
  logic [31:0]  target;
  logic         is_halt;
  logic         load, squash;

  assign target  = redirect_pc & ~32'd3;
  assign is_halt = (imem_data == HALT_INSTR);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_BOOT;
    else        state <= state_next;
  end

  // PC and pending-redirect target registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      pend_pc <= 32'h0;
    end else begin
      pc      <= pc_next;
      pend_pc <= pend_next;
    end
  end

  // Next-state logic: redirect beats stall beats a normal fetch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN: begin
        if (redirect_valid) begin
          if (stall) state_next = ST_REDIR_PEND;
`ifdef FETCH_DELAY_SLOT_EN
          else if (is_halt) state_next = ST_HALT;
`endif
        end else if (!stall && is_halt) begin
          state_next = ST_HALT;
        end
      end
      ST_REDIR_PEND: if (!stall) state_next = ST_RUN;
      ST_HALT:       state_next = ST_HALT;
      default:       state_next = ST_BOOT;
    endcase
  end

  // PC selection and IF/ID load/squash control for the current state.
  always_comb begin
    pc_next   = pc;
    pend_next = pend_pc;
    load      = 1'b0;
    squash    = 1'b0;
    case (state)
      ST_RUN: begin
        if (redirect_valid && !stall) begin
          pc_next = target;
`ifdef FETCH_DELAY_SLOT_EN
          load    = 1'b1;
`else
          squash  = 1'b1;
`endif
        end else if (redirect_valid) begin
          pend_next = target;
        end else if (!stall) begin
          pc_next = add4(pc);
          load    = 1'b1;
        end
      end
      ST_REDIR_PEND: begin
        if (stall) begin
          if (redirect_valid) pend_next = target;
        end else begin
          pc_next = pend_pc;
`ifndef FETCH_DELAY_SLOT_EN
          squash  = 1'b1;
`endif
        end
      end
      ST_HALT: squash = 1'b1;
      default: ;
    endcase
  end

  // Externally visible fetch address, trace PC and halt flag.
  always_comb begin
    imem_addr = pc[IMEM_AW+1:2];
    pc_out    = pc;
    halted    = (state == ST_HALT);
  end

  fetch_stage_ifid_reg u_ifid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .squash   (squash),
    .valid_in (1'b1),
    .instr_in (imem_data),
    .pc4_in   (add4(pc)),
    .valid    (ifid_valid),
    .instr    (ifid_instr),
    .pc4      (ifid_pc4)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a per-edge behavioural model of the fetch
// rules is compared with the DUT on every falling edge, and literal
// expectations at key points pin both model and DUT.
module tb_fetch_stage;

  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic [31:0] pc_out;
  logic        halted;

  logic [31:0] rom [256];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign imem_data = rom[imem_addr];

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc4       (ifid_pc4),
    .pc_out         (pc_out),
    .halted         (halted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the fetch rules.
  logic [31:0] m_pc = 32'h0, m_pend = 32'h0, m_instr = 32'h0, m_pc4 = 32'h0;
  logic        m_valid = 1'b0, m_boot = 1'b1, m_waiting = 1'b0, m_halted = 1'b0;
  logic [31:0] word;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_pend = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
      m_boot = 1'b1; m_waiting = 1'b0; m_halted = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_halted) begin
      m_valid = 1'b0; m_instr = 32'h0;
    end else if (m_waiting) begin
      if (stall) begin
        if (redirect_valid) m_pend = {redirect_pc[31:2], 2'b00};
      end else begin
        m_pc = m_pend;
        m_waiting = 1'b0;
`ifndef FETCH_DELAY_SLOT_EN
        m_valid = 1'b0; m_instr = 32'h0;
`endif
      end
    end else if (redirect_valid && stall) begin
      m_pend = {redirect_pc[31:2], 2'b00};
      m_waiting = 1'b1;
    end else if (redirect_valid) begin
      word = rom[m_pc[9:2]];
`ifdef FETCH_DELAY_SLOT_EN
      m_valid = 1'b1; m_instr = word; m_pc4 = m_pc + 32'd4;
      if (word == HALT_W) m_halted = 1'b1;
`else
      m_valid = 1'b0; m_instr = 32'h0;
`endif
      m_pc = {redirect_pc[31:2], 2'b00};
    end else if (!stall) begin
      word = rom[m_pc[9:2]];
      m_valid = 1'b1; m_instr = word; m_pc4 = m_pc + 32'd4;
      m_pc = m_pc + 32'd4;
      if (word == HALT_W) m_halted = 1'b1;
    end
  end

  // Every falling edge: DUT against model.
  always @(negedge clk) begin
    check("pc_out", pc_out, m_pc);
    check("imem_addr", {24'h0, imem_addr}, {24'h0, m_pc[9:2]});
    check("ifid_valid", {31'h0, ifid_valid}, {31'h0, m_valid});
    check("ifid_instr", ifid_instr, m_instr);
    check("ifid_pc4", ifid_pc4, m_pc4);
    check("halted", {31'h0, halted}, {31'h0, m_halted});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'h2001_0001 + i;
    rom[5] = HALT_W;

    // Reset state.
    tick(2);
    check("rst_pc", pc_out, 32'h0);
    check("rst_valid", {31'h0, ifid_valid}, 32'h0);
    check("rst_pc4", ifid_pc4, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    rst_n = 1'b1;

    // BOOT cycle: nothing captured.
    tick(1);
    check("boot_valid", {31'h0, ifid_valid}, 32'h0);
    tick(1);
    check("run0_pc4", ifid_pc4, 32'd4);
    check("run0_instr", ifid_instr, 32'h2001_0001);
    tick(1);
    check("run1_pc4", ifid_pc4, 32'd8);
    check("run1_instr", ifid_instr, 32'h2001_0002);

    // Stall three cycles at pc = 8.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check("stall_pc", pc_out, 32'd8);
      check("stall_pc4", ifid_pc4, 32'd8);
      check("stall_instr", ifid_instr, 32'h2001_0002);
    end
    stall = 1'b0;
    tick(1);
    check("unstall_pc4", ifid_pc4, 32'd12);
    check("unstall_instr", ifid_instr, 32'h2001_0003);
    tick(1);
    check("pc_10", pc_out, 32'h10);

    // Redirect to 0x43 at pc = 0x10.
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    tick(1);
    redirect_valid = 1'b0;
    check("redir_pc", pc_out, 32'h40);
`ifdef FETCH_DELAY_SLOT_EN
    check("ds_valid", {31'h0, ifid_valid}, 32'h1);
    check("ds_instr", ifid_instr, 32'h2001_0005);
    check("ds_pc4", ifid_pc4, 32'h14);
`else
    check("sq_valid", {31'h0, ifid_valid}, 32'h0);
    check("sq_instr", ifid_instr, 32'h0);
`endif
    tick(2);
    check("after_redir_pc4", ifid_pc4, 32'h48);
    check("after_redir_instr", ifid_instr, 32'h2001_0012);

    // Redirect to 0x80 under a two-cycle stall.
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick(1);
    redirect_valid = 1'b0;
    check("pend_pc_hold0", pc_out, 32'h48);
    tick(1);
    check("pend_pc_hold1", pc_out, 32'h48);
    stall = 1'b0;
    tick(1);
    check("pend_release_pc", pc_out, 32'h80);
`ifdef FETCH_DELAY_SLOT_EN
    check("pend_keep_valid", {31'h0, ifid_valid}, 32'h1);
    check("pend_keep_pc4", ifid_pc4, 32'h48);
`else
    check("pend_sq_valid", {31'h0, ifid_valid}, 32'h0);
`endif

    // PC wrap through the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick(1);
    redirect_valid = 1'b0;
    check("wrap_addr_hi", {24'h0, imem_addr}, 32'hFF);
    tick(1);
    check("wrap_pc4", ifid_pc4, 32'h0);
    check("wrap_instr", ifid_instr, 32'h2001_0100);
    check("wrap_pc", pc_out, 32'h0);
    check("wrap_addr_lo", {24'h0, imem_addr}, 32'h0);
    tick(1);

    // Async reset in the middle of a pending redirect.
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick(1);
    redirect_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_pc", pc_out, 32'h0);
    check("async_valid", {31'h0, ifid_valid}, 32'h0);
    check("async_instr", ifid_instr, 32'h0);
    check("async_pc4", ifid_pc4, 32'h0);
    stall = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    check("restart_pc", pc_out, 32'h4);
    check("restart_pc4", ifid_pc4, 32'h4);

    // Run into the HALT word at 0x14.
    tick(5);
    check("halt_flag", {31'h0, halted}, 32'h1);
    check("halt_pc", pc_out, 32'h18);
    check("halt_instr", ifid_instr, HALT_W);
    check("halt_valid_cap", {31'h0, ifid_valid}, 32'h1);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick(1);
    check("halt_valid_off", {31'h0, ifid_valid}, 32'h0);
    stall = 1'b1;
    tick(2);
    check("halt_ignore_pc", pc_out, 32'h18);
    check("halt_sticky", {31'h0, halted}, 32'h1);
    redirect_valid = 1'b0; stall = 1'b0;
    tick(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
